// File: rtl/rtype_pkg.sv
// rtype_pkg: shared opcodes, ALU op encoding and pipeline register layouts for rtype_pipe_datapath
package rtype_pkg;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        alu_op_e    op;
        logic       use_imm;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } idex_t;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic [4:0] rd;
        logic       zero;
        logic       lt;
        logic       gt;
    } exwb_t;

    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic sub, input logic sra);
        case (f3)
            F3_ADD:  return sub ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return sra ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/rtype_alu.sv
// rtype_alu: combinational integer ALU with zero and signed compare flags
module rtype_alu
    import rtype_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            lt,
    output logic            gt
);
    localparam int SW = $clog2(XLEN);
    logic [SW-1:0] sh;
    logic          ltu;
    assign sh   = b[SW-1:0];
    assign lt   = $signed(a) < $signed(b);
    assign gt   = $signed(a) > $signed(b);
    assign ltu  = a < b;
    assign zero = result == '0;
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << sh;
            ALU_SLT:  result = XLEN'(lt);
            ALU_SLTU: result = XLEN'(ltu);
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> sh;
            ALU_SRA:  result = XLEN'($signed(a) >>> sh);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end
endmodule

// File: rtl/rtype_pipe_datapath.sv
// rtype_pipe_datapath: 3-stage OP/OP-IMM execution pipe with register file and full forwarding
module rtype_pipe_datapath
    import rtype_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_valid,
    input  logic [31:0]         inst,
    output logic                inst_ready,
    input  logic                stall,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                is_zero,
    output logic                is_blt,
    output logic                is_bgt,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retire_count,
    input  logic [4:0]          dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);
    localparam int AW = $clog2(NREGS);

    idex_t               idex_q, idex_d;
    exwb_t               exwb_q, exwb_d;
    logic [XLEN-1:0]     a_q, a_d, b_q, b_d, wb_data_q, wb_data_d;
    logic [XLEN-1:0]     regs_q [NREGS];
    logic [XLEN-1:0]     regs_d [NREGS];
    logic [RETIRE_W-1:0] retire_q, retire_d;
    logic [6:0]          opc, f7;
    logic [2:0]          f3;
    logic [4:0]          rd, rs1, rs2;
    logic                is_op, is_imm, sh_zero, sh_alt, legal, wb_we, fwd;
    logic [XLEN-1:0]     imm, rs1_val, rs2_val, alu_a, alu_b, alu_y;
    logic                alu_zero, alu_lt, alu_gt;

    assign {f7, rs2, rs1, f3, rd, opc} = inst;
    assign is_op   = opc == OPC_OP;
    assign is_imm  = opc == OPC_OPIMM;
    assign sh_zero = XLEN == 64 ? inst[31:26] == 6'b000000 : f7 == 7'b0000000;
    assign sh_alt  = XLEN == 64 ? inst[31:26] == 6'b010000 : f7 == 7'b0100000;
    assign legal   = ((is_op && (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == F3_ADD || f3 == F3_SR))))
                   || (is_imm && (f3 == F3_SLL ? sh_zero : f3 == F3_SR ? sh_zero || sh_alt : 1'b1)))
                   && !(NREGS == 16 && (rd[4] || rs1[4] || (is_op && rs2[4])));
    assign imm     = {{(XLEN-12){inst[31]}}, inst[31:20]};

    // The committing WB result is bypassed into the ID read so no stall is needed.
    assign wb_we   = exwb_q.valid && exwb_q.rd != 5'd0 && !stall;
    assign rs1_val = rs1 == 5'd0 ? '0 : wb_we && exwb_q.rd == rs1 ? wb_data_q : regs_q[rs1[AW-1:0]];
    assign rs2_val = rs2 == 5'd0 ? '0 : wb_we && exwb_q.rd == rs2 ? wb_data_q : regs_q[rs2[AW-1:0]];

    assign fwd   = exwb_q.valid && exwb_q.rd != 5'd0;
    assign alu_a = fwd && exwb_q.rd == idex_q.rs1 ? wb_data_q : a_q;
    assign alu_b = fwd && !idex_q.use_imm && exwb_q.rd == idex_q.rs2 ? wb_data_q : b_q;

    rtype_alu #(.XLEN(XLEN)) u_alu (
        .op     (idex_q.op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_y),
        .zero   (alu_zero),
        .lt     (alu_lt),
        .gt     (alu_gt)
    );

    always_comb begin
        idex_d    = idex_q;
        exwb_d    = exwb_q;
        a_d       = a_q;
        b_d       = b_q;
        wb_data_d = wb_data_q;
        regs_d    = regs_q;
        retire_d  = retire_q;
        if (!stall) begin
            idex_d = '{valid: inst_valid && legal, illegal: inst_valid && !legal,
                       op: f3_to_op(f3, is_op && inst[30], inst[30]), use_imm: is_imm,
                       rd: rd, rs1: rs1, rs2: rs2};
            a_d = rs1_val;
            b_d = is_imm ? imm : rs2_val;
            exwb_d = '{valid: idex_q.valid, illegal: idex_q.illegal, rd: idex_q.rd,
                       zero: idex_q.valid && alu_zero, lt: idex_q.valid && alu_lt,
                       gt: idex_q.valid && alu_gt};
            wb_data_d = alu_y;
            if (wb_we) regs_d[exwb_q.rd[AW-1:0]] = wb_data_q;
            retire_d = retire_q + RETIRE_W'(exwb_q.valid);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idex_q    <= '0;
            exwb_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wb_data_q <= '0;
            regs_q    <= '{default: '0};
            retire_q  <= '0;
        end else begin
            idex_q    <= idex_d;
            exwb_q    <= exwb_d;
            a_q       <= a_d;
            b_q       <= b_d;
            wb_data_q <= wb_data_d;
            regs_q    <= regs_d;
            retire_q  <= retire_d;
        end
    end

    assign inst_ready   = !stall;
    assign wb_valid     = exwb_q.valid;
    assign wb_rd        = exwb_q.rd;
    assign wb_data      = wb_data_q;
    assign is_zero      = exwb_q.zero;
    assign is_blt       = exwb_q.lt;
    assign is_bgt       = exwb_q.gt;
    assign illegal      = exwb_q.illegal;
    assign retire_count = retire_q;
    assign dbg_data     = dbg_addr == 5'd0 || (NREGS == 16 && dbg_addr[4]) ? '0 : regs_q[dbg_addr[AW-1:0]];
endmodule

// File: doc/rtype_pipe_datapath.md
Name: rtype_pipe_datapath

Overview:
Three-stage pipelined integer execution datapath for RV32I/RV64I register-register (OP) and register-immediate (OP-IMM) instructions. It contains its own register file and full result forwarding, so no stall is ever generated internally. Instructions arrive on a valid/ready stream from the fetch unit. Branch-compare flags go to the PC/next-PC logic.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
NREGS, 32, architectural register count; legal values 16 (RV32E) or 32
RETIRE_W, 32, width of the retire counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
inst_valid  in  1  instruction available
inst  in  32  instruction word
inst_ready  out  1  equals !stall
stall  in  1  freezes every pipeline register and blocks the register-file write
wb_valid  out  1  legal result present in the WB stage
wb_rd  out  5  destination register of the WB instruction
wb_data  out  XLEN  result of the WB instruction
is_zero  out  1  WB result == 0
is_blt  out  1  signed opA < opB, taken from the WB instruction
is_bgt  out  1  signed opA > opB, taken from the WB instruction
illegal  out  1  one-cycle pulse for a rejected instruction
retire_count  out  RETIRE_W  number of committed instructions
dbg_addr  in  5  debug register-read address
dbg_data  out  XLEN  combinational register-file read at dbg_addr; x0 reads 0

Behaviour:
- Reset (reset==0 at a clk edge):
  - clears all registers, the ID/EX and EX/WB valid bits, and retire_count.
  - All outputs read 0 in the following cycle.
  - Reset overrides stall. Instructions in flight are dropped.
- Accept: an instruction is accepted at an edge where inst_valid && inst_ready.
- ID stage (at accept):
  - Decode the instruction.
  - Read rs1/rs2 from the register file. If the WB stage is writing the same nonzero register in that cycle, the write data is bypassed into the read.
  - Sign-extend the I-immediate to XLEN.
  - Load the ID/EX register.
- EX stage (next edge):
  - The ALU uses the forwarded operand whenever EX/WB is valid with rd!=0 and rd matches a source; otherwise it uses the ID/EX operand.
  - opB is rs2 for OP and the immediate for OP-IMM.
  - Result and flags are registered into EX/WB.
- WB stage: wb_valid=1 in the cycle after the EX edge. The register-file write and the retire_count increment both commit at the following unstalled edge.
- Latency: an instruction accepted at edge E0 drives wb_* in the cycle after E1 and commits at E2. Throughput is one instruction per clock.
- Supported operations:
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- Shift amount: opB[$clog2(XLEN)-1:0].
  - XLEN=64: immediate-shift funct7 check uses inst[31:26] (6-bit shamt).
  - XLEN=32: inst[25]=1 on an immediate shift is illegal.
- SLT/SLTU write 1 or 0, zero-extended.
- Illegal instruction: unknown opcode, bad funct7, or (when NREGS=16) a register field ≥16.
  - Becomes a bubble in ID/EX with the illegal tag set.
  - illegal pulses for one cycle when the bubble reaches EX/WB.
  - No write, no retire, wb_valid=0.
- x0:
  - reads return 0;
  - writes are discarded;
  - rd=0 is never a forwarding source;
  - the instruction still counts as retired.
- stall=1: every stage holds its contents. wb_* outputs are held stable. No commit, no accept.
- retire_count wraps modulo 2^RETIRE_W.
- is_* flags are valid only while wb_valid=1; otherwise they are 0.

Decomposition:
- Package rtype_pkg:
  - opcode constants OPC_OP=7'b0110011 and OPC_OPIMM=7'b0010011;
  - funct3 constants;
  - alu_op_e enum (ADD…AND);
  - idex_t and exwb_t pipeline structs.
- Sub-module rtype_alu: purely combinational, takes XLEN, drives result plus the zero/lt/gt flags.
- Register file, forwarding and decode stay in the top module.

Test Plan:
- Reset then 0x00500093 (ADDI x1,x0,5), 0xFFD00113 (ADDI x2,x0,-3), 0x002081B3 (ADD x3,x1,x2) back-to-back -> wb_data sequence 5, 0xFFFFFFFD, 2. The ADD result exercises EX/WB forwarding for x2 and the ID bypass for x1. retire_count=3.
- Continue with 0x00112233 (SLT x4,x2,x1) -> wb_data=1, is_blt=1, is_bgt=0, is_zero=0. dbg_addr=4 then reads 1.
- 0x00A00013 (ADDI x0,x0,10) followed by ADD x5,x0,x0 -> wb_data=10 first, then 0. x0 stays 0. retire_count increments by 2.
- Opcode 0x7F, or 0x40001013 (SLLI with funct7 0x20) -> illegal pulses one cycle, wb_valid=0, no register change, retire_count unchanged.
- stall held for 3 cycles with two instructions in flight -> wb_* stable for those 3 cycles, inst_ready=0. Both instructions commit after release with correct forwarding.
- reset asserted while the pipeline is full -> no commit at that edge, all registers read 0, retire_count=0. The next instruction after release executes normally.
